// File: rtl/us_scan_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : us_scan_scheduler
//  Description : Round-robin scheduler sharing one ultrasonic ranging engine
//                across several trig/echo transducers. Fires one sensor at a
//                time, measures the echo pulse width in clock cycles, flags
//                timeouts and keeps a per-sensor near-obstacle flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module us_scan_scheduler #(
  parameter int NUM_SENSORS    = 3,
  parameter int TRIG_CYCLES    = 1200,
  parameter int TIMEOUT_CYCLES = 3000000,
  parameter int GAP_CYCLES     = 500000,
  parameter int NEAR_MIN       = 10000,
  parameter int NEAR_MAX       = 220000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic [NUM_SENSORS-1:0] echo,
  output logic [NUM_SENSORS-1:0] trig,
  output logic                   meas_valid,
  output logic [1:0]             meas_id,
  output logic [23:0]            meas_width,
  output logic                   meas_timeout,
  output logic [NUM_SENSORS-1:0] near,
  output logic                   busy
);

  // Terminal counts and range limits, pre-sized to the 24-bit counters
  localparam logic [23:0] TRIG_LAST    = 24'(TRIG_CYCLES - 1);
  localparam logic [23:0] TIMEOUT_LAST = 24'(TIMEOUT_CYCLES - 1);
  localparam logic [23:0] GAP_LAST     = 24'(GAP_CYCLES - 1);
  localparam logic [23:0] NEAR_MIN_C   = 24'(NEAR_MIN);
  localparam logic [23:0] NEAR_MAX_C   = 24'(NEAR_MAX);
  localparam logic [1:0]  LAST_IDX     = 2'(NUM_SENSORS - 1);
  localparam logic [23:0] WIDTH_SAT    = 24'hFFFFFF;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_TRIG      = 3'd1,
    S_WAIT_RISE = 3'd2,
    S_MEASURE   = 3'd3,
    S_GAP       = 3'd4
  } state_t;

  state_t state;
  state_t state_next;

  logic [1:0]             idx;
  logic [1:0]             idx_next;
  logic [23:0]            cnt;
  logic [23:0]            tcnt;
  logic [23:0]            width;
  logic [NUM_SENSORS-1:0] sync1;
  logic [NUM_SENSORS-1:0] es;
  logic [NUM_SENSORS-1:0] es_d;
  logic [NUM_SENSORS-1:0] rise_vec;
  logic [NUM_SENSORS-1:0] fall_vec;
  logic [NUM_SENSORS-1:0] trig_next;
  logic                   rise_sel;
  logic                   fall_sel;
  logic                   es_sel;
  logic                   emit;
  logic                   emit_timeout;
  logic                   in_range;

  // Edges are only of interest on the sensor currently being served
  assign rise_vec = es & ~es_d;
  assign fall_vec = ~es & es_d;
  assign rise_sel = rise_vec[idx];
  assign fall_sel = fall_vec[idx];
  assign es_sel   = es[idx];
  assign in_range = (width >= NEAR_MIN_C) && (width <= NEAR_MAX_C);
  assign busy     = (state != S_IDLE);

  // Two-flop synchronizer plus one delay stage for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      es    <= '0;
      es_d  <= '0;
    end else begin
      sync1 <= echo;
      es    <= sync1;
      es_d  <= es;
    end
  end

  // State and sensor-index register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      idx   <= 2'd0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  // Next-state logic and result-decision flags
  always_comb begin
    state_next   = state;
    idx_next     = idx;
    emit         = 1'b0;
    emit_timeout = 1'b0;
    case (state)
      S_IDLE: begin
        idx_next = 2'd0;
        if (enable) state_next = S_TRIG;
      end
      S_TRIG: begin
        if (cnt == TRIG_LAST) state_next = S_WAIT_RISE;
      end
      S_WAIT_RISE: begin
        // Only a fresh edge counts; an echo already high on entry has no rise
        if (rise_sel) begin
          state_next = S_MEASURE;
        end else if (tcnt == TIMEOUT_LAST) begin
          emit         = 1'b1;
          emit_timeout = 1'b1;
          state_next   = S_GAP;
        end
      end
      S_MEASURE: begin
        // A fall coinciding with the timeout is reported as a normal result
        if (fall_sel) begin
          emit       = 1'b1;
          state_next = S_GAP;
        end else if (tcnt == TIMEOUT_LAST) begin
          emit         = 1'b1;
          emit_timeout = 1'b1;
          state_next   = S_GAP;
        end
      end
      S_GAP: begin
        if (cnt == GAP_LAST) begin
          if (enable) begin
            state_next = S_TRIG;
            idx_next   = (idx == LAST_IDX) ? 2'd0 : idx + 2'd1;
          end else begin
            state_next = S_IDLE;
            idx_next   = 2'd0;
          end
        end
      end
      default: begin
        state_next = S_IDLE;
        idx_next   = 2'd0;
      end
    endcase
  end

  // Trigger is registered from the next state so it lines up exactly with TRIG
  always_comb begin
    trig_next = '0;
    for (int i = 0; i < NUM_SENSORS; i++) begin
      trig_next[i] = (state_next == S_TRIG) && (idx_next == 2'(i));
    end
  end

  // Slot counters, echo width accumulator and trigger output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      tcnt  <= '0;
      width <= '0;
      trig  <= '0;
    end else begin
      trig <= trig_next;

      if (state_next != state) begin
        cnt <= '0;
      end else if (state == S_TRIG || state == S_GAP) begin
        cnt <= cnt + 24'd1;
      end else begin
        cnt <= '0;
      end

      if (state == S_WAIT_RISE || state == S_MEASURE) begin
        tcnt <= tcnt + 24'd1;
      end else begin
        tcnt <= '0;
      end

      if (state == S_TRIG) begin
        width <= '0;
      end else if (state == S_WAIT_RISE && rise_sel) begin
        width <= 24'd1;
      end else if (state == S_MEASURE && es_sel && width != WIDTH_SAT) begin
        width <= width + 24'd1;
      end
    end
  end

  // Result publication, one cycle after the fall/timeout decision
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meas_valid   <= 1'b0;
      meas_id      <= 2'd0;
      meas_width   <= '0;
      meas_timeout <= 1'b0;
      near         <= '0;
    end else begin
      meas_valid <= emit;
      if (emit) begin
        meas_id      <= idx;
        meas_timeout <= emit_timeout;
        meas_width   <= emit_timeout ? WIDTH_SAT : width;
        near[idx]    <= ~emit_timeout & in_range;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/us_scan_scheduler.md
Name: us_scan_scheduler

Overview:
- Time-multiplexes one ultrasonic ranging engine across NUM_SENSORS trig/echo transducers (front/left/right).
- Fires one sensor at a time so cross-talk cannot occur. Measures echo pulse width in clock cycles and flags timeouts.
- Publishes per-sensor near-obstacle flags for the motion/steering controller that drives the motor ctr code.

Parameters:
- NUM_SENSORS, 3, number of transducers; 2..4; index width is 2 bits.
- TRIG_CYCLES, 1200, trig pulse length in clk cycles (12 us at 100 MHz).
- TIMEOUT_CYCLES, 3000000, maximum cycles from trig end to echo fall (30 ms).
- GAP_CYCLES, 500000, dead time after each slot before the next trig (5 ms).
- NEAR_MIN, 10000, minimum width (inclusive) counted as a valid near obstacle.
- NEAR_MAX, 220000, maximum width (inclusive) counted as a near obstacle.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  run continuous round-robin scanning.
- echo  in  NUM_SENSORS  raw echo inputs, asynchronous.
- trig  out  NUM_SENSORS  trigger outputs, one-hot or zero.
- meas_valid  out  1  one-cycle result strobe.
- meas_id  out  2  sensor index of the result.
- meas_width  out  24  echo width in cycles; 24'hFFFFFF on timeout.
- meas_timeout  out  1  result was a timeout (qualified by meas_valid).
- near  out  NUM_SENSORS  per-sensor near flag, held until that sensor's next result.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- **Reset.**
  - Asynchronous, active-low.
  - State = IDLE, idx = 0, all counters 0, synchronizers 0.
  - trig = 0, meas_valid = 0, meas_id = 0, meas_width = 0, meas_timeout = 0, near = 0, busy = 0.
  - Reset asserted mid-slot aborts immediately. trig drops asynchronously. No result is emitted.
- **Echo synchronizer.**
  - Each echo bit passes through a 2-flop synchronizer, giving es.
  - A 3rd register holds es_d for edge detection.
  - rise = es & ~es_d; fall = ~es & es_d, both evaluated on bit idx only.
- **FSM states:** IDLE, TRIG, WAIT_RISE, MEASURE, GAP.
- **IDLE:**
  - enable=1 -> TRIG, cnt=0.
- **TRIG:**
  - trig[idx]=1; all other trig bits 0.
  - trig is registered, high for exactly TRIG_CYCLES cycles.
  - Then -> WAIT_RISE, tcnt=0.
- **WAIT_RISE:**
  - tcnt increments each cycle.
  - rise on idx -> MEASURE, width=1.
  - Echo already high on entry (stale) is ignored; a fresh rise is required.
  - tcnt reaching TIMEOUT_CYCLES-1 before a rise -> timeout result, then GAP.
- **MEASURE:**
  - tcnt continues incrementing.
  - es[idx]=1 -> width+1, saturating at 24'hFFFFFF.
  - fall -> normal result, then GAP.
  - tcnt reaching TIMEOUT_CYCLES-1 before fall -> timeout result, then GAP.
  - If timeout and fall occur in the same cycle, fall wins.
- **Width definition:** meas_width equals the number of cycles es[idx] was high. This equals the raw pulse length for clean pulses.
- **Result:**
  - On the cycle after the fall or timeout decision: meas_valid=1 for one cycle, meas_id=idx.
  - meas_width and meas_timeout are updated.
  - meas_width and meas_id hold their values until the next result.
  - near[idx] = ~timeout & (NEAR_MIN ≤ width ≤ NEAR_MAX). Other near bits are unchanged.
- **GAP:**
  - Lasts GAP_CYCLES cycles. Then idx advances: idx = (idx == NUM_SENSORS-1) ? 0 : idx+1.
  - If enable=1 -> TRIG; else -> IDLE with idx forced to 0.
- **enable deasserted mid-slot:** the current slot, including its result and GAP, completes. enable is sampled only at the end of GAP and in IDLE.
- **Counters:**
  - cnt and tcnt are 24 bits; width is 24 bits.
  - Parameters must fit in 24 bits.
- **Arithmetic:** no combinational path from echo to any output.

Test Plan:
- Sim parameters: NUM_SENSORS=3, TRIG_CYCLES=10, TIMEOUT_CYCLES=1000, GAP_CYCLES=50, NEAR_MIN=20, NEAR_MAX=200.
- **Round-robin:** enable=1; each echo answers 30 cycles after its trig falls with a 100-cycle pulse.
  - trig[0], trig[1], trig[2], trig[0] fire in order, each 10 cycles wide.
  - Three strobes: id 0,1,2, width=100, timeout=0.
  - near=3'b111.
- **Timeout:** echo[1] held low.
  - Strobe id=1, width=24'hFFFFFF, timeout=1, at 1000 cycles after trig[1] fall (+1).
  - near[1]=0; next trig is trig[2].
- **Range bounds:** widths 19, 20, 200, 201 on sensor 0 across scans -> near[0] = 0, 1, 1, 0 respectively.
- **Stale echo:** echo[2] high before trig[2], falls 5 cycles into WAIT_RISE, then rises for 50 cycles -> width=50, timeout=0.
- **Stop/reset:**
  - Drop enable during MEASURE of sensor 1: result is emitted, GAP completes, then IDLE with busy=0. Re-enable -> trig[0] fires next.
  - Assert rst_n=0 mid-TRIG: trig=0 immediately, no meas_valid, near=0.
